gate_array_registered: RTL and testbench

Parametrised, pipelined array of N-input logic gates with per-input inversion bubbles, selectable gate function and valid tracking. Generalises the fixed 4-input combinational AND gate to NrOfChannels independent gates of NrOfInputs inputs each. Sits between the 6502 decode/control logic and registered consumers where reduced decode terms must be retimed and, optionally, deglitched.

---
 rtl/gate_array_registered.sv | 125 ++++++++++++
 tb/tb_gate_array_registered.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_array_registered.sv
// Pipelined array of N-input gates with per-input bubbles, selectable function and valid tracking.
// Optional per-channel deglitch filter on the output, enabled by defining GATE_DEGLITCH_EN.
module gate_array_registered #(
  parameter int unsigned            NrOfInputs   = 4,
  parameter int unsigned            NrOfChannels = 1,
  parameter logic [NrOfInputs-1:0]  BubblesMask  = '0,
  parameter int unsigned            GateMode     = 0,
  parameter int unsigned            PipeStages   = 1,
  parameter int unsigned            FilterCycles = 2
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 tick_i,
  input  logic                                 valid_in_i,
  input  logic [NrOfChannels*NrOfInputs-1:0]   inputs_i,
  output logic                                 valid_out_o,
  output logic [NrOfChannels-1:0]              result_o
);

  localparam int unsigned LastStage = PipeStages - 1;

  // Out-of-range filter lengths leave a named marker in the elaborated hierarchy.
  if (FilterCycles == 0 || FilterCycles > 15) begin : g_illegal_filter_cycles
  end

  function automatic logic gate_f(input logic [NrOfInputs-1:0] x);
    logic [NrOfInputs-1:0] r;
    r = x ^ BubblesMask;
    case (GateMode)
      1:       return ~&r;
      2:       return |r;
      3:       return ~|r;
      4:       return ^r;
      5:       return ~^r;
      default: return &r;
    endcase
  endfunction

  logic [NrOfChannels-1:0] gate_c;

  always_comb begin
    gate_c = '0;
    for (int unsigned c = 0; c < NrOfChannels; c++) begin
      gate_c[c] = gate_f(inputs_i[c*NrOfInputs +: NrOfInputs]);
    end
  end

  // Shift register of {result, valid}; data moves regardless of valid.
  logic [NrOfChannels-1:0] data_q [PipeStages];
  logic [NrOfChannels-1:0] data_d [PipeStages];
  logic [PipeStages-1:0]   vld_q;
  logic [PipeStages-1:0]   vld_d;

  always_comb begin
    data_d    = data_q;
    vld_d     = vld_q;
    data_d[0] = gate_c;
    vld_d[0]  = valid_in_i;
    for (int unsigned s = 1; s < PipeStages; s++) begin
      data_d[s] = data_q[s-1];
      vld_d[s]  = vld_q[s-1];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned s = 0; s < PipeStages; s++) begin
        data_q[s] <= '0;
      end
      vld_q <= '0;
    end else if (tick_i) begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

`ifdef GATE_DEGLITCH_EN
  logic [3:0]              cnt_q [NrOfChannels];
  logic [3:0]              cnt_d [NrOfChannels];
  logic [NrOfChannels-1:0] filt_q;
  logic [NrOfChannels-1:0] filt_d;
  logic                    vout_q;
  logic                    vout_d;

  // A channel output flips only after FilterCycles consecutive differing valid samples.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    vout_d = vld_q[LastStage];
    if (vld_q[LastStage]) begin
      for (int unsigned c = 0; c < NrOfChannels; c++) begin
        if (data_q[LastStage][c] == filt_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == 4'(FilterCycles - 1)) begin
          filt_d[c] = data_q[LastStage][c];
          cnt_d[c]  = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned c = 0; c < NrOfChannels; c++) begin
        cnt_q[c] <= '0;
      end
      filt_q <= '0;
      vout_q <= 1'b0;
    end else if (tick_i) begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      vout_q <= vout_d;
    end
  end

  assign result_o    = filt_q;
  assign valid_out_o = vout_q;
`else
  assign result_o    = data_q[LastStage];
  assign valid_out_o = vld_q[LastStage];
`endif

endmodule

// File: tb/tb_gate_array_registered.sv
// Bench for gate_array_registered: eight differently configured instances share one stimulus
// word; expectations come from a sample-history reference model (plus filter model when deglitched).
module tb_gate_array_registered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tick;
  logic        vin;
  logic [31:0] word;

  logic [3:0]  i0;
  logic [11:0] i1;
  logic [3:0]  i2;
  logic [7:0]  i3;
  logic [7:0]  i4;
  logic [9:0]  i5;
  logic [5:0]  i6;
  logic [1:0]  i7;
  assign i0 = word[3:0];
  assign i1 = word[11:0];
  assign i2 = word[3:0];
  assign i3 = word[7:0];
  assign i4 = word[7:0];
  assign i5 = word[9:0];
  assign i6 = word[5:0];
  assign i7 = word[1:0];

  logic [0:0] r0;
  logic [2:0] r1;
  logic [0:0] r2;
  logic [1:0] r3;
  logic [1:0] r4;
  logic [1:0] r5;
  logic [1:0] r6;
  logic [0:0] r7;
  logic [7:0] v;

  gate_array_registered #(.NrOfInputs(4), .NrOfChannels(1), .BubblesMask(4'b0000), .GateMode(0),
    .PipeStages(1), .FilterCycles(3)) u0 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i0), .valid_out_o(v[0]), .result_o(r0));
  gate_array_registered #(.NrOfInputs(4), .NrOfChannels(3), .BubblesMask(4'b0000), .GateMode(4),
    .PipeStages(3), .FilterCycles(2)) u1 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i1), .valid_out_o(v[1]), .result_o(r1));
  gate_array_registered #(.NrOfInputs(4), .NrOfChannels(1), .BubblesMask(4'b0101), .GateMode(0),
    .PipeStages(1), .FilterCycles(1)) u2 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i2), .valid_out_o(v[2]), .result_o(r2));
  gate_array_registered #(.NrOfInputs(4), .NrOfChannels(2), .BubblesMask(4'b0000), .GateMode(7),
    .PipeStages(1), .FilterCycles(2)) u3 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i3), .valid_out_o(v[3]), .result_o(r3));
  gate_array_registered #(.NrOfInputs(4), .NrOfChannels(2), .BubblesMask(4'b0000), .GateMode(1),
    .PipeStages(2), .FilterCycles(2)) u4 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i4), .valid_out_o(v[4]), .result_o(r4));
  gate_array_registered #(.NrOfInputs(5), .NrOfChannels(2), .BubblesMask(5'b10011), .GateMode(5),
    .PipeStages(4), .FilterCycles(4)) u5 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i5), .valid_out_o(v[5]), .result_o(r5));
  gate_array_registered #(.NrOfInputs(3), .NrOfChannels(2), .BubblesMask(3'b010), .GateMode(3),
    .PipeStages(2), .FilterCycles(1)) u6 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i6), .valid_out_o(v[6]), .result_o(r6));
  gate_array_registered #(.NrOfInputs(2), .NrOfChannels(1), .BubblesMask(2'b01), .GateMode(2),
    .PipeStages(1), .FilterCycles(2)) u7 (.clock_i(clk), .reset_i(rst), .tick_i(tick),
    .valid_in_i(vin), .inputs_i(i7), .valid_out_o(v[7]), .result_o(r7));

  localparam int          NI   [8] = '{4, 4, 4, 4, 4, 5, 3, 2};
  localparam int          NC   [8] = '{1, 3, 1, 2, 2, 2, 2, 1};
  localparam logic [15:0] MSK  [8] = '{16'h0, 16'h0, 16'h5, 16'h0, 16'h0, 16'h13, 16'h2, 16'h1};
  localparam int          MODE [8] = '{0, 4, 0, 7, 1, 5, 3, 2};
  localparam int          PS   [8] = '{1, 3, 1, 1, 2, 4, 2, 1};
  localparam int          FC   [8] = '{3, 2, 1, 2, 2, 4, 1, 2};

  int tests = 0;
  int fails = 0;

  // History of every sample the pipelines accepted; a reset appends cleared entries.
  logic        hz [4096];
  logic        hv [4096];
  logic [31:0] hw [4096];
  int          idx = -1;

  logic [31:0] fres_m [8];
  int          run_m  [8][32];
  logic        vout_m [8];

  function automatic logic gate_ref(input int mode, input logic [15:0] bits,
                                    input logic [15:0] mask, input int ni);
    logic [15:0] x;
    int ones;
    x = bits ^ mask;
    ones = 0;
    for (int i = 0; i < ni; i++) ones += int'(x[i]);
    case (mode)
      1:       return ones != ni;
      2:       return ones != 0;
      3:       return ones == 0;
      4:       return (ones % 2) == 1;
      5:       return (ones % 2) == 0;
      default: return ones == ni;
    endcase
  endfunction

  function automatic logic [31:0] fdata(input int k, input logic [31:0] w);
    logic [31:0] res;
    logic [31:0] sl;
    res = '0;
    for (int c = 0; c < NC[k]; c++) begin
      sl = (w >> (c * NI[k])) & ((32'd1 << NI[k]) - 32'd1);
      res[c] = gate_ref(MODE[k], sl[15:0], MSK[k], NI[k]);
    end
    return res;
  endfunction

  function automatic logic last_v(input int k);
    int e;
    e = idx - PS[k] + 1;
    return hz[e] ? 1'b0 : hv[e];
  endfunction

  function automatic logic [31:0] last_d(input int k);
    int e;
    e = idx - PS[k] + 1;
    return hz[e] ? 32'd0 : fdata(k, hw[e]);
  endfunction

  function automatic void push(input logic z, input logic vi, input logic [31:0] w);
    if (idx < 4095) idx++;
    hz[idx] = z;
    hv[idx] = vi;
    hw[idx] = w;
  endfunction

  function automatic void model_edge(input logic r, input logic t, input logic vi,
                                     input logic [31:0] w);
    logic        lv;
    logic [31:0] ld;
    if (r) begin
      for (int j = 0; j < 8; j++) push(1'b1, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) begin
        fres_m[k] = '0;
        vout_m[k] = 1'b0;
        for (int c = 0; c < 32; c++) run_m[k][c] = 0;
      end
    end else if (t) begin
      for (int k = 0; k < 8; k++) begin
        lv = last_v(k);
        ld = last_d(k);
        if (lv) begin
          for (int c = 0; c < NC[k]; c++) begin
            if (ld[c] == fres_m[k][c]) run_m[k][c] = 0;
            else if (run_m[k][c] + 1 == FC[k]) begin
              fres_m[k][c] = ld[c];
              run_m[k][c] = 0;
            end else run_m[k][c]++;
          end
        end
        vout_m[k] = lv;
      end
      push(1'b0, vi, w);
    end
  endfunction

  function automatic logic [31:0] obs_r(input int k);
    case (k)
      0:       return 32'(r0);
      1:       return 32'(r1);
      2:       return 32'(r2);
      3:       return 32'(r3);
      4:       return 32'(r4);
      5:       return 32'(r5);
      6:       return 32'(r6);
      default: return 32'(r7);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] er;
    logic        ev;
    for (int k = 0; k < 8; k++) begin
`ifdef GATE_DEGLITCH_EN
      er = fres_m[k];
      ev = vout_m[k];
`else
      er = last_d(k);
      ev = last_v(k);
`endif
      chk($sformatf("model_result_u%0d", k), obs_r(k), er);
      chk($sformatf("model_valid_u%0d", k), 32'(v[k]), 32'(ev));
    end
  endtask

  task automatic step(input logic r, input logic t, input logic vi, input logic [31:0] w);
    rst  = r;
    tick = t;
    vin  = vi;
    word = w;
    @(posedge clk);
    model_edge(r, t, vi, w);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; vin = 1'b0; word = '0;

    // Reset with NAND inputs all zero: outputs stay cleared, reset beats tick.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("nand_rst_result", 32'(r4), 32'd0);
    chk("nand_rst_valid", 32'(v[4]), 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'd0);
    chk("nand_rst_result_tick", 32'(r4), 32'd0);
    chk("nand_rst_valid_tick", 32'(v[4]), 32'd0);

    step(1'b0, 1'b1, 1'b1, 32'd0);
`ifndef GATE_DEGLITCH_EN
    chk("nand_first_tick_result", 32'(r4), 32'd0);
    chk("nand_first_tick_valid", 32'(v[4]), 32'd0);
`endif
    step(1'b0, 1'b1, 1'b1, 32'd0);
`ifndef GATE_DEGLITCH_EN
    chk("nand_emerge_result", 32'(r4), 32'd3);
    chk("nand_emerge_valid", 32'(v[4]), 32'd1);
`endif

    step(1'b0, 1'b1, 1'b1, 32'hF);
`ifndef GATE_DEGLITCH_EN
    chk("and_1111_result", 32'(r0), 32'd1);
    chk("and_1111_valid", 32'(v[0]), 32'd1);
`endif
    step(1'b0, 1'b1, 1'b1, 32'hE);
`ifndef GATE_DEGLITCH_EN
    chk("and_1110_result", 32'(r0), 32'd0);
`endif
    step(1'b0, 1'b1, 1'b1, 32'hA);
`ifndef GATE_DEGLITCH_EN
    chk("bubble_1010_result", 32'(r2), 32'd1);
`endif
    step(1'b0, 1'b1, 1'b1, 32'hF);
`ifndef GATE_DEGLITCH_EN
    chk("bubble_1111_result", 32'(r2), 32'd0);
`endif

    // XOR array with a long tick stall in the middle of the pipe.
    step(1'b0, 1'b1, 1'b1, 32'h731);
    step(1'b0, 1'b1, 1'b1, $urandom);
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    step(1'b0, 1'b1, 1'b1, $urandom);
`ifndef GATE_DEGLITCH_EN
    chk("xor3_result", 32'(r1), 32'h5);
    chk("xor3_valid", 32'(v[1]), 32'd1);
`endif

    for (int j = 0; j < 6; j++) step(1'b0, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b1, $urandom);
    chk("mid_reset_valids", 32'(v), 32'd0);
    chk("mid_reset_nand_result", 32'(r4), 32'd0);

    // Illegal mode against AND over every nibble.
    for (int j = 0; j < 16; j++) begin
      step(1'b0, 1'b1, 1'b1, 32'(j * 17));
`ifndef GATE_DEGLITCH_EN
      chk($sformatf("mode7_as_and_%0d", j), 32'(r3), (j == 15) ? 32'd3 : 32'd0);
`endif
    end

    // Deglitch: short pulse rejected, held change accepted, valid gaps hold the run.
    for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b1, 32'h0);
    for (int j = 0; j < 2; j++) step(1'b0, 1'b1, 1'b1, 32'hF);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b1, 1'b1, 32'h0);
`ifdef GATE_DEGLITCH_EN
      chk($sformatf("pulse_rejected_%0d", j), 32'(r0), 32'd0);
`endif
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, 1'b1, 32'hF);
`ifdef GATE_DEGLITCH_EN
      chk($sformatf("change_latency_%0d", j), 32'(r0), (j == 3) ? 32'd1 : 32'd0);
`endif
    end
    for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 1'(j % 2 == 0), 32'h0);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b1, 32'h0);

    for (int j = 0; j < 300; j++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 3) != 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
